ask4_symbol_mapper: RTL and testbench
=====================================

Name: ask4_symbol_mapper

Overview:
Transmit-side 4-ASK symbol generator; the counterpart of the receive-path power/reference estimator.
- Maps 2-bit symbols, from an internal PRBS or an external source, to levels ±a/±3a in 1s17, at the symbol rate set by clk_en.
- Emits a frame strobe aligned to the receiver's accumulation window, so the receiver's clear_accum can be driven from it.
- Publishes the ideal reference level (2a) and mapper power (5a²) for loopback checking.

Parameters:
FRAME_LOG2, 20, log2 of symbols per frame; matches the receiver's 1/N shift.
LFSR_SEED, 22'h000001, nonzero PRBS reset state.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
clk_en  in  1  symbol-rate enable; one symbol is requested per high cycle
src_sel  in  1  0 = internal PRBS, 1 = external data
data_in  in  2  external symbol bits {b1,b0}
data_valid  in  1  external data valid
data_ready  out  1  external data accepted this cycle
amplitude  in  18  signed 1s17 level a; negative values are treated as 0
symbol_out  out  18  signed 1s17 mapped level
symbol_valid  out  1  one-cycle pulse, new symbol_out
frame_start  out  1  pulses with symbol_valid on the first symbol of each frame
underflow  out  1  sticky flag: external data missing when requested
expected_ref  out  18  signed 1s17, sat(2a)
expected_power  out  18  signed 1s17, sat(5a²)

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs go to 0.
  - LFSR loads LFSR_SEED; frame counter is 0; the pipeline is flushed.
  - Reset asserted mid-operation discards any in-flight symbol.
- data_ready is combinational: data_ready = clk_en & src_sel. A transfer occurs when data_ready & data_valid.
- Stage 1 (edge ending a clk_en cycle): capture bits b.
  - src_sel=0: the LFSR (x^22+x^21+1, Fibonacci) advances two steps; b1 = first new bit, b0 = second. The LFSR advances only in this case.
  - src_sel=1 with data_valid=1: b = data_in.
  - src_sel=1 with data_valid=0: the symbol is marked "null" and underflow is set. underflow stays 1 until reset.
- Stage 2 (next edge): symbol_out is registered and symbol_valid=1 for exactly one cycle.
  - Latency is 2 clocks from the clk_en cycle to symbol_valid.
  - symbol_out holds between pulses.
  - clk_en pulses closer than 1 idle cycle apart are still supported; the pipeline is fully pipelined with throughput 1/clock.
- Gray mapping, with amplitude sampled at stage 2:
  - 00 -> -3a
  - 01 -> -a
  - 11 -> +a
  - 10 -> +3a
  - null -> 0
- Arithmetic:
  - 3a = a + (a<<1), computed at 20 bits, then saturated to [-131072, 131071].
  - -3a saturates to -131072.
  - ±a never saturates.
- Frame counter: FRAME_LOG2 bits, increments on each symbol_valid (including null symbols) and wraps to 0.
  - frame_start = symbol_valid & (counter==0), so the first symbol after reset is a frame start.
- expected_ref / expected_power:
  - On each frame_start cycle, a is latched.
  - The cycle after that, expected_ref = sat18(2a).
  - expected_power = sat18((5·a·a) >>> 17), computed with a 36-bit product and 39-bit sum.
  - Both hold until the next frame_start.
- src_sel changes take effect at the next clk_en; the LFSR state is retained across a switch.
- clk_en held low: no state changes; the pipeline drains normally.

Decomposition:
- Shared package:
  - SYM_W=18
  - SAT_MAX=131071, SAT_MIN=-131072
  - Gray-map codes (SYM_M3=2'b00, SYM_M1=2'b01, SYM_P1=2'b11, SYM_P3=2'b10)
  - LFSR taps and width
  - sat18 function
- One sub-module: prbs22_gen. It has enable, a 2-bit output per step and the async active-low reset, and is reusable by the bit-error checker on the receive side.

Test Plan:
1. Reset; amplitude=32768; src_sel=1; data 00,01,11,10 with clk_en every 4 clocks -> symbol_out -98304, -32768, 32768, 98304, each with symbol_valid exactly 2 clocks after its clk_en; data_ready high only in clk_en cycles.
2. amplitude=65536; data 10 then 00 -> 131071 then -131072 (saturated); data 11 -> 65536.
3. FRAME_LOG2=4; src_sel=0; clk_en every cycle -> frame_start on symbols 0, 16, 32; symbols match the software LFSR model from seed 1; no 0 levels.
4. src_sel=1, data_valid=0 at a clk_en -> symbol_out=0 with symbol_valid=1; underflow=1 and stays 1 through later valid data until reset.
5. amplitude=32768 -> after the first frame_start, expected_ref=65536 and expected_power=40960 (0.3125); amplitude=-5 -> a treated as 0, all symbols 0, expected values 0 at the next frame.
6. Pull reset low mid-frame between clk_en and symbol_valid -> all outputs 0 immediately, no symbol_valid afterwards; after release, the first symbol carries frame_start and the PRBS restarts from the seed.

Source files
------------

// File: rtl/ask4_symbol_mapper_pkg.sv
// Shared types, constants and saturation helper for the 4-ASK transmit mapper.
// Latency: none (package only).
// Backpressure: none (package only).
package ask4_symbol_mapper_pkg;

  localparam int SYM_W = 18;

  // 1s17 saturation bounds: +0.99999 and -1.0
  localparam logic signed [SYM_W-1:0] SAT_MAX = 18'sh1FFFF;
  localparam logic signed [SYM_W-1:0] SAT_MIN = 18'sh20000;

  // Gray-coded symbol bits: adjacent levels differ in exactly one bit
  typedef enum logic [1:0] {
    SYM_M3 = 2'b00,
    SYM_M1 = 2'b01,
    SYM_P1 = 2'b11,
    SYM_P3 = 2'b10
  } sym_code_t;

  // PRBS22 polynomial x^22 + x^21 + 1 as Fibonacci taps on the two oldest bits
  localparam int LFSR_W      = 22;
  localparam int LFSR_TAP_HI = 21;
  localparam int LFSR_TAP_LO = 20;

  // Clamp a wide signed intermediate into the 1s17 range.
  function automatic logic signed [SYM_W-1:0] sat18(input logic signed [39:0] v);
    if (v > 40'sd131071) begin
      return SAT_MAX;
    end else if (v < -40'sd131072) begin
      return SAT_MIN;
    end else begin
      return v[SYM_W-1:0];
    end
  endfunction

endpackage

// File: rtl/prbs22_gen.sv
// PRBS22 (x^22+x^21+1) Fibonacci generator producing two new bits per enabled step.
// Latency: bits are combinational from the current state; state advances two steps per enable.
// Backpressure: none; the caller holds enable low to freeze the sequence.
//   clk    - clock
//   reset  - asynchronous active-low reset, loads SEED
//   enable - advance the register by two steps at this edge
//   bits   - {first new bit, second new bit} the next enabled step will shift in
module prbs22_gen
  import ask4_symbol_mapper_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 22'h000001
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic [1:0] bits
);

  logic [LFSR_W-1:0] state;
  logic              nb1;
  logic              nb2;

  // Second bit uses the taps one position down, i.e. the state after the first shift.
  assign nb1  = state[LFSR_TAP_HI] ^ state[LFSR_TAP_LO];
  assign nb2  = state[LFSR_TAP_HI-1] ^ state[LFSR_TAP_LO-1];
  assign bits = {nb1, nb2};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= SEED;
    end else if (enable) begin
      state <= {state[LFSR_W-3:0], nb1, nb2};
    end
  end

endmodule

// File: rtl/ask4_symbol_mapper.sv
// 4-ASK symbol mapper: Gray-coded 2-bit symbols (PRBS or external) to +-a/+-3a in 1s17, with frame strobe and reference outputs.
// Latency: 2 clocks from a clk_en cycle to the symbol_valid pulse; fully pipelined at 1 symbol/clock.
// Backpressure: none; external data is taken when clk_en & src_sel, missing data yields a zero symbol and sticky underflow.
//   clk, reset      - clock, asynchronous active-low reset
//   clk_en          - symbol request strobe
//   src_sel         - 0 internal PRBS, 1 external data_in/data_valid (data_ready = clk_en & src_sel)
//   amplitude       - level a in 1s17, negative clamps to 0
//   symbol_out/_valid, frame_start, underflow - mapped stream and status
//   expected_ref/_power - sat(2a), sat(5a^2) latched at each frame start
module ask4_symbol_mapper
  import ask4_symbol_mapper_pkg::*;
#(
  parameter int                FRAME_LOG2 = 20,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = 22'h000001
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk_en,
  input  logic                    src_sel,
  input  logic [1:0]              data_in,
  input  logic                    data_valid,
  output logic                    data_ready,
  input  logic signed [SYM_W-1:0] amplitude,
  output logic signed [SYM_W-1:0] symbol_out,
  output logic                    symbol_valid,
  output logic                    frame_start,
  output logic                    underflow,
  output logic signed [SYM_W-1:0] expected_ref,
  output logic signed [SYM_W-1:0] expected_power
);

  logic [1:0]            prbs_bits;
  logic                  s1_vld;
  logic                  s1_null;
  sym_code_t             s1_bits;
  logic [FRAME_LOG2-1:0] frame_cnt;

  logic signed [SYM_W-1:0] a_pos;
  logic signed [19:0]      a20;
  logic signed [19:0]      a3_20;
  logic signed [19:0]      a2_20;
  logic signed [35:0]      a36;
  logic signed [35:0]      prod;
  logic signed [38:0]      sum39;
  logic signed [39:0]      pwr40;
  logic signed [SYM_W-1:0] sym_next;
  logic signed [SYM_W-1:0] ref_next;
  logic signed [SYM_W-1:0] pwr_next;

  assign data_ready = clk_en & src_sel;

  // PRBS only advances when it actually supplies a symbol, so switching to
  // external data and back resumes the sequence where it left off.
  prbs22_gen #(
    .SEED(LFSR_SEED)
  ) u_prbs (
    .clk    (clk),
    .reset  (reset),
    .enable (clk_en & ~src_sel),
    .bits   (prbs_bits)
  );

  // Amplitude arithmetic; a is forced non-negative so all products below are non-negative.
  assign a_pos = amplitude[SYM_W-1] ? '0 : amplitude;
  assign a20   = {2'b00, a_pos};
  assign a3_20 = a20 + (a20 <<< 1);
  assign a2_20 = a20 <<< 1;
  assign a36   = {18'd0, a_pos};
  assign prod  = a36 * a36;
  assign sum39 = {3'b000, prod} + {1'b0, prod, 2'b00};
  assign pwr40 = {1'b0, sum39} >>> 17;

  assign ref_next = sat18({{20{a2_20[19]}}, a2_20});
  assign pwr_next = sat18(pwr40);

  always_comb begin
    sym_next = '0;
    if (!s1_null) begin
      case (s1_bits)
        SYM_M3:  sym_next = sat18(-{{20{a3_20[19]}}, a3_20});
        SYM_M1:  sym_next = -a_pos;
        SYM_P1:  sym_next = a_pos;
        SYM_P3:  sym_next = sat18({{20{a3_20[19]}}, a3_20});
        default: sym_next = '0;
      endcase
    end
  end

  // Stage 1: capture the symbol bits at the edge ending the clk_en cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld    <= 1'b0;
      s1_null   <= 1'b0;
      s1_bits   <= SYM_M3;
      underflow <= 1'b0;
    end else begin
      s1_vld <= clk_en;
      if (clk_en) begin
        s1_null <= src_sel & ~data_valid;
        s1_bits <= sym_code_t'(src_sel ? data_in : prbs_bits);
        if (src_sel && !data_valid) begin
          underflow <= 1'b1;
        end
      end
    end
  end

  // Stage 2: map with the current amplitude, strobe, and count frames.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      symbol_out     <= '0;
      symbol_valid   <= 1'b0;
      frame_start    <= 1'b0;
      frame_cnt      <= '0;
      expected_ref   <= '0;
      expected_power <= '0;
    end else begin
      symbol_valid <= s1_vld;
      frame_start  <= s1_vld && (frame_cnt == '0);
      if (s1_vld) begin
        symbol_out <= sym_next;
        frame_cnt  <= frame_cnt + 1'b1;
      end
      // The amplitude seen during the frame_start cycle becomes the reference.
      if (frame_start) begin
        expected_ref   <= ref_next;
        expected_power <= pwr_next;
      end
    end
  end

endmodule

// File: tb/tb_ask4_symbol_mapper.sv
// Directed bench for ask4_symbol_mapper with a per-cycle reference model and literal pins.
// Latency: model expects symbol_valid two clocks after each clk_en cycle.
// Backpressure: none exercised beyond data_valid gaps.
module tb_ask4_symbol_mapper;

  localparam int          FL     = 4;
  localparam int          FRAMES = 1 << FL;
  localparam logic [21:0] SEED   = 22'h000001;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              clk_en = 1'b0;
  logic              src_sel = 1'b0;
  logic [1:0]        data_in = 2'b00;
  logic              data_valid = 1'b0;
  logic              data_ready;
  logic signed [17:0] amplitude = 18'sd0;
  logic signed [17:0] symbol_out;
  logic              symbol_valid;
  logic              frame_start;
  logic              underflow;
  logic signed [17:0] expected_ref;
  logic signed [17:0] expected_power;

  ask4_symbol_mapper #(.FRAME_LOG2(FL), .LFSR_SEED(SEED)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .src_sel(src_sel),
    .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
    .amplitude(amplitude), .symbol_out(symbol_out), .symbol_valid(symbol_valid),
    .frame_start(frame_start), .underflow(underflow),
    .expected_ref(expected_ref), .expected_power(expected_power)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  function automatic int clampa(input int amp);
    return (amp < 0) ? 0 : amp;
  endfunction

  function automatic int sat(input longint v);
    if (v > 131071) return 131071;
    if (v < -131072) return -131072;
    return int'(v);
  endfunction

  // Level = k*a for Gray-ordered k in {-3,-1,+1,+3}, clamped to 1s17.
  function automatic int level(input bit nul, input bit [1:0] b, input int amp);
    int k;
    if (nul) return 0;
    case (b)
      2'b00:   k = -3;
      2'b01:   k = -1;
      2'b11:   k = 1;
      default: k = 3;
    endcase
    return sat(longint'(k) * clampa(amp));
  endfunction

  typedef struct {
    int     due;
    bit     nul;
    bit [1:0] bits;
    int     lvl;
  } ent_t;

  ent_t   pq[$];
  bit     seq[$];          // PRBS history, oldest first: x[n] = x[n-22] ^ x[n-21]
  int     seen[$];         // symbol_out values observed on symbol_valid
  bit     seen_fs[$];      // frame_start observed alongside
  int     cyc = 0;
  int     m_sym = 0, m_cnt = 0, m_ref = 0, m_pwr = 0;
  bit     m_uf = 0;

  function automatic void prbs_reset();
    seq.delete();
    for (int i = 21; i >= 0; i--) seq.push_back(SEED[i]);
  endfunction

  function automatic bit prbs_next();
    bit nb;
    nb = seq[0] ^ seq[1];
    seq.push_back(nb);
    void'(seq.pop_front());
    return nb;
  endfunction

  initial prbs_reset();

  // Model and compare, once per cycle on the falling edge.
  always @(negedge clk) begin
    bit   exp_v, exp_fs;
    ent_t e;
    cyc++;
    if (symbol_valid) begin
      seen.push_back(int'(symbol_out));
      seen_fs.push_back(frame_start);
    end
    if (!reset) begin
      pq.delete();
      m_sym = 0; m_cnt = 0; m_ref = 0; m_pwr = 0; m_uf = 0;
      prbs_reset();
      chk("rst_valid", symbol_valid, 0);
      chk("rst_sym", symbol_out, 0);
      chk("rst_fs", frame_start, 0);
      chk("rst_uf", underflow, 0);
      chk("rst_ref", expected_ref, 0);
      chk("rst_pwr", expected_power, 0);
    end else begin
      exp_v  = (pq.size() > 0) && (pq[0].due == cyc);
      exp_fs = exp_v && ((m_cnt % FRAMES) == 0);
      if (exp_v) m_sym = pq[0].lvl;
      chk("valid", symbol_valid, exp_v);
      chk("sym", symbol_out, m_sym);
      chk("fs", frame_start, exp_fs);
      chk("uf", underflow, m_uf);
      chk("ref", expected_ref, m_ref);
      chk("pwr", expected_power, m_pwr);
      chk("ready", data_ready, clk_en & src_sel);
      if (exp_v) begin
        void'(pq.pop_front());
        m_cnt++;
      end
      if (exp_fs) begin
        m_ref = sat(2 * longint'(clampa(int'(amplitude))));
        m_pwr = sat((5 * longint'(clampa(int'(amplitude))) * clampa(int'(amplitude))) >>> 17);
      end
      // Amplitude is sampled at the edge that registers the symbol.
      foreach (pq[i]) if (pq[i].due == cyc + 1) pq[i].lvl = level(pq[i].nul, pq[i].bits, int'(amplitude));
      if (clk_en) begin
        e.due = cyc + 2;
        e.lvl = 0;
        if (!src_sel) begin
          e.nul = 0;
          e.bits[1] = prbs_next();
          e.bits[0] = prbs_next();
        end else begin
          e.nul  = !data_valid;
          e.bits = data_in;
          if (!data_valid) m_uf = 1;
        end
        pq.push_back(e);
      end
    end
  end

  task automatic send(input bit src, input bit dv, input logic [1:0] d, input int gap);
    @(posedge clk); #1;
    clk_en = 1'b1; src_sel = src; data_valid = dv; data_in = d;
    @(posedge clk); #1;
    clk_en = 1'b0; data_valid = 1'b0;
    repeat (gap - 1) @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic burst(input int n);
    @(posedge clk); #1;
    src_sel = 1'b0; clk_en = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    clk_en = 1'b0;
  endtask

  initial begin
    int nz;
    int fsn;
    int fsi[$];

    // Reset state
    idle(3);
    @(negedge clk);
    chk("init_sym", symbol_out, 0);
    chk("init_ref", expected_ref, 0);
    @(posedge clk); #1;
    reset = 1'b1; amplitude = 18'sd32768; src_sel = 1'b1;

    // Gray map with external data, clk_en every 4 clocks
    seen.delete(); seen_fs.delete();
    send(1, 1, 2'b00, 4);
    send(1, 1, 2'b01, 4);
    send(1, 1, 2'b11, 4);
    send(1, 1, 2'b10, 4);
    idle(4);
    chk("t1_count", seen.size(), 4);
    chk("t1_m3", seen[0], -98304);
    chk("t1_m1", seen[1], -32768);
    chk("t1_p1", seen[2], 32768);
    chk("t1_p3", seen[3], 98304);
    chk("t1_fs0", seen_fs[0], 1);
    chk("t5_ref", expected_ref, 65536);
    chk("t5_pwr", expected_power, 40960);

    // Saturation at a = 0.5
    amplitude = 18'sd65536;
    seen.delete(); seen_fs.delete();
    send(1, 1, 2'b10, 4);
    send(1, 1, 2'b00, 4);
    send(1, 1, 2'b11, 4);
    idle(4);
    chk("t2_count", seen.size(), 3);
    chk("t2_p3sat", seen[0], 131071);
    chk("t2_m3sat", seen[1], -131072);
    chk("t2_p1", seen[2], 65536);

    // Underflow: missing data gives a null symbol, flag is sticky
    seen.delete(); seen_fs.delete();
    send(1, 0, 2'b11, 4);
    send(1, 1, 2'b01, 4);
    idle(4);
    chk("t4_null", seen[0], 0);
    chk("t4_after", seen[1], -65536);
    chk("t4_sticky", underflow, 1);

    // Restart, PRBS at full rate with 16-symbol frames
    @(posedge clk); #1; reset = 1'b0;
    idle(2);
    reset = 1'b1; amplitude = 18'sd32768;
    seen.delete(); seen_fs.delete();
    burst(40);
    idle(4);
    chk("t3_count", seen.size(), 40);
    chk("t3_sym0", seen[0], -98304);
    chk("t3_sym10", seen[10], 32768);
    nz = 0; fsi.delete();
    foreach (seen[i]) begin
      if (seen[i] == 0) nz++;
      if (seen_fs[i]) fsi.push_back(i);
    end
    chk("t3_zero_levels", nz, 0);
    fsn = fsi.size();
    chk("t3_fs_count", fsn, 3);
    chk("t3_fs_a", fsi[0], 0);
    chk("t3_fs_b", fsi[1], 16);
    chk("t3_fs_c", fsi[2], 32);

    // Negative amplitude behaves as zero
    amplitude = -18'sd5;
    seen.delete(); seen_fs.delete();
    burst(20);
    idle(4);
    nz = 0;
    foreach (seen[i]) if (seen[i] != 0) nz++;
    chk("t5_neg_count", seen.size(), 20);
    chk("t5_neg_nonzero", nz, 0);
    chk("t5_neg_ref", expected_ref, 0);
    chk("t5_neg_pwr", expected_power, 0);

    // Populate nonzero state, then reset with a symbol in flight
    amplitude = 18'sd32768;
    burst(20);
    idle(4);
    chk("t6_pre_ref", expected_ref, 65536);
    @(posedge clk); #1;
    clk_en = 1'b1; src_sel = 1'b0;
    @(posedge clk); #1;
    clk_en = 1'b0; reset = 1'b0;
    seen.delete(); seen_fs.delete();
    #1;
    chk("t6_sym", symbol_out, 0);
    chk("t6_ref", expected_ref, 0);
    chk("t6_pwr", expected_power, 0);
    idle(3);
    chk("t6_no_valid", seen.size(), 0);
    reset = 1'b1;
    idle(1);
    seen.delete(); seen_fs.delete();
    send(0, 1, 2'b00, 4);
    idle(3);
    chk("t6_count", seen.size(), 1);
    chk("t6_first", seen[0], -98304);
    chk("t6_first_fs", seen_fs[0], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
